fpu_operand_unpack: RTL and testbench
=====================================

// Module: fpu_operand_unpack
// PURPOSE
//  Front end of the FP32 add/sub unit in the FFT butterfly datapath. Accepts two
//  IEEE-754 single operands and an add/sub select over a valid/ready handshake.
//  Splits each operand into sign/exponent/fraction and classifies it (zero, inf,
//  NaN, denormal). Applies the effective sign of B and registers the result with
//  a skid buffer. Outputs drive the special-case resolver and the align/add path.
// PARAMETERS
//  FTZ     1   1: denormal inputs flush to zero; 0: denormals pass through unflushed
//  TAG_W   3   width of the sideband tag (butterfly index) carried with each operand pair
//  CNT_W   16  width of the saturating NaN statistics counter
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      asynchronous reset, active-high
//  in_valid       in   1      operand pair valid
//  in_ready       out  1      unit can accept a pair
//  a, b           in   32     IEEE-754 single operands
//  sub            in   1      1 = A-B, 0 = A+B
//  in_tag         in   TAG_W  sideband tag
//  out_valid      out  1      unpacked pair valid
//  out_ready      in   1      downstream accepts the pair
//  sign_a         out  1      sign of A
//  sign_b_eff     out  1      b[31]^sub
//  exp_a, exp_b   out  8      biased exponents
//  frac_a, frac_b out  23     fractions (forced to 0 when flushed)
//  mant_a, mant_b out  24     {hidden bit, frac}; hidden = (exp!=0)
//  is_zero_a/b    out  1      zero class (includes flushed denormals)
//  is_inf_a/b     out  1      infinity class
//  is_nan_a/b     out  1      NaN class (quiet or signalling)
//  is_denorm_a/b  out  1      raw input had exp==0 and frac!=0 (reported even when flushed)
//  out_tag        out  TAG_W  tag of the pair on the output
//  clr_stats      in   1      synchronous clear of nan_count
//  nan_count      out  CNT_W  count of NaN operands accepted, saturating
// BEHAVIOUR
//  Reset (async, rst=1): out_valid=0, skid empty, in_ready=1, all data/tag outputs 0, nan_count=0.
//  Classification per operand x, with e=x[30:23] and f=x[22:0]:
//   - NaN: e=FF and f!=0. Inf: e=FF and f=0. Zero: e=0 and f=0.
//   - Denorm: e=0 and f!=0. FTZ=1 sets is_zero=1, frac=0, mant=0, is_denorm=1, sign kept.
//   - Class flags are one-hot or all-zero. is_denorm may coexist with is_zero only when FTZ=1.
//  Handshake:
//   - Accept occurs when in_valid && in_ready. Transfer occurs when out_valid && out_ready.
//   - Inputs need not stay stable after they are accepted.
//  Pipeline: one output register (OR) plus one skid register (SK).
//   - in_ready = !SK_valid. It is a direct register output, with no combinational path from out_ready.
//   - Latency: the pair accepted in cycle N is visible in cycle N+1 when OR is empty or transfers in N.
//   - Accept while OR is full and not transferring: the pair goes to SK, and in_ready falls next cycle.
//   - SK full and OR transfers: SK moves to OR. Any pair accepted that cycle goes to SK only if OR still
//     cannot take it. in_ready never admits a third entry.
//   - Order is strictly FIFO. No pair is dropped or duplicated. Back-to-back throughput is 1 pair/cycle.
//   - out_* data holds stable while out_valid && !out_ready.
//  nan_count:
//   - Adds is_nan_a+is_nan_b (0..2) of each accepted pair at accept time. Saturates at 2^CNT_W-1,
//     with no wrap; an increment of 2 at max-1 clamps to max.
//   - clr_stats together with an increment in the same cycle: the clear wins and the result is 0.
//  Reset mid-stream: all in-flight pairs are discarded, and out_valid drops at the assertion of rst.
// TESTING
//  a=3F800000, b=40000000, sub=1, tag=5, out_ready=1 -> next cycle out_valid=1, sign_b_eff=1,
//    exp_a=7F, mant_a=800000, mant_b=800000, exp_b=80, all class flags 0, out_tag=5.
//  a=7FC00000, b=FF800000 -> is_nan_a=1, is_inf_b=1, sign_b_eff=1 (sub=0), nan_count 0->1.
//  FTZ=1, a=00000001, b=80000000 -> is_zero_a=1, is_denorm_a=1, frac_a=0, mant_a=0, is_zero_b=1.
//    With FTZ=0: frac_a=1, mant_a=000001, is_zero_a=0.
//  Stream of 8 pairs with out_ready toggling 1,0,0,1,... -> in_ready falls only when SK is full.
//    Outputs appear in order with tags 0..7, none lost, data stable during stall.
//  Preload nan_count=FFFE, then accept a pair with two NaNs -> FFFF, and a further NaN pair holds FFFF.
//    clr_stats together with a NaN accept -> 0.
//  Fill OR+SK, then assert rst mid-cycle -> out_valid=0 immediately, in_ready=1, nan_count=0.

Source files
------------

// File: rtl/fpu_operand_unpack.sv
// FP32 add/sub operand front end: splits and classifies two operands, applies the
// effective sign of B, and registers the pair through an output register plus skid buffer.
module fpu_operand_unpack #(
  parameter int FTZ   = 1,
  parameter int TAG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign_a,
  output logic             sign_b_eff,
  output logic [7:0]       exp_a,
  output logic [7:0]       exp_b,
  output logic [22:0]      frac_a,
  output logic [22:0]      frac_b,
  output logic [23:0]      mant_a,
  output logic [23:0]      mant_b,
  output logic             is_zero_a,
  output logic             is_zero_b,
  output logic             is_inf_a,
  output logic             is_inf_b,
  output logic             is_nan_a,
  output logic             is_nan_b,
  output logic             is_denorm_a,
  output logic             is_denorm_b,
  output logic [TAG_W-1:0] out_tag,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] nan_count
);

  // Per-operand record: {sign, exp[7:0], frac[22:0], zero, inf, nan, denorm}
  localparam int OPW = 36;
  localparam int RW  = 2 * OPW + TAG_W;

  function automatic logic [OPW-1:0] unpack_op(input logic [31:0] x, input logic neg);
    logic [7:0]  e;
    logic [22:0] f;
    logic        den;
    logic        flush;
    logic        zero;
    logic        inf;
    logic        nan;
    e     = x[30:23];
    f     = x[22:0];
    den   = (e == 8'h00) && (f != 23'd0);
    flush = (FTZ != 0) && den;
    zero  = (e == 8'h00) && ((f == 23'd0) || flush);
    inf   = (e == 8'hFF) && (f == 23'd0);
    nan   = (e == 8'hFF) && (f != 23'd0);
    return {x[31] ^ neg, e, flush ? 23'd0 : f, zero, inf, nan, den};
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  logic [OPW-1:0]   ua, ub;
  logic [RW-1:0]    in_rec;
  logic             acc, xfer;
  logic [1:0]       nan_inc;

  logic             or_vld_q, or_vld_d;
  logic             sk_vld_q, sk_vld_d;
  logic [RW-1:0]    or_q, or_d;
  logic [RW-1:0]    sk_q, sk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign ua      = unpack_op(a, 1'b0);
  assign ub      = unpack_op(b, sub);
  assign in_rec  = {ua, ub, in_tag};
  assign in_ready = ~sk_vld_q;
  assign acc     = in_valid & ~sk_vld_q;
  assign xfer    = or_vld_q & out_ready;
  assign nan_inc = acc ? ({1'b0, ua[1]} + {1'b0, ub[1]}) : 2'd0;

  // Next-state: skid drains into OR first; a new pair lands in OR when it frees up, else in SK
  always_comb begin
    or_vld_d = or_vld_q;
    sk_vld_d = sk_vld_q;
    or_d     = or_q;
    sk_d     = sk_q;
    if (sk_vld_q) begin
      if (xfer) begin
        or_d     = sk_q;
        sk_vld_d = 1'b0;
      end
    end else if (acc) begin
      if (!or_vld_q || xfer) begin
        or_d     = in_rec;
        or_vld_d = 1'b1;
      end else begin
        sk_d     = in_rec;
        sk_vld_d = 1'b1;
      end
    end else if (xfer) begin
      or_vld_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_stats) begin
      cnt_d = '0;
    end else if (nan_inc != 2'd0) begin
      cnt_d = sat_add(cnt_q, nan_inc);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      or_vld_q <= 1'b0;
      sk_vld_q <= 1'b0;
      or_q     <= '0;
      sk_q     <= '0;
      cnt_q    <= '0;
    end else begin
      or_vld_q <= or_vld_d;
      sk_vld_q <= sk_vld_d;
      or_q     <= or_d;
      sk_q     <= sk_d;
      cnt_q    <= cnt_d;
    end
  end

  // Output decode from the output register
  assign out_valid   = or_vld_q;
  assign nan_count   = cnt_q;
  assign out_tag     = or_q[TAG_W-1:0];

  assign sign_a      = or_q[RW-1];
  assign exp_a       = or_q[RW-2 -: 8];
  assign frac_a      = or_q[RW-10 -: 23];
  assign is_zero_a   = or_q[TAG_W+OPW+3];
  assign is_inf_a    = or_q[TAG_W+OPW+2];
  assign is_nan_a    = or_q[TAG_W+OPW+1];
  assign is_denorm_a = or_q[TAG_W+OPW];

  assign sign_b_eff  = or_q[TAG_W+OPW-1];
  assign exp_b       = or_q[TAG_W+OPW-2 -: 8];
  assign frac_b      = or_q[TAG_W+OPW-10 -: 23];
  assign is_zero_b   = or_q[TAG_W+3];
  assign is_inf_b    = or_q[TAG_W+2];
  assign is_nan_b    = or_q[TAG_W+1];
  assign is_denorm_b = or_q[TAG_W];

  assign mant_a      = {exp_a != 8'h00, frac_a};
  assign mant_b      = {exp_b != 8'h00, frac_b};

endmodule

// File: tb/tb_fpu_operand_unpack.sv
// Bench for fpu_operand_unpack: FTZ=1 and FTZ=0 instances share stimulus and are
// checked against a queue-based reference model built from the IEEE-754 class rules.
module tb_fpu_operand_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, sub, out_ready, clr_stats;
  logic [31:0] a, b;
  logic [2:0]  in_tag;

  logic        in_ready, out_valid, sign_a, sign_b_eff;
  logic [7:0]  exp_a, exp_b;
  logic [22:0] frac_a, frac_b;
  logic [23:0] mant_a, mant_b;
  logic        is_zero_a, is_zero_b, is_inf_a, is_inf_b, is_nan_a, is_nan_b, is_denorm_a, is_denorm_b;
  logic [2:0]  out_tag;
  logic [15:0] nan_count;

  logic        in_ready0, out_valid0, sign_a0, sign_b_eff0;
  logic [7:0]  exp_a0, exp_b0;
  logic [22:0] frac_a0, frac_b0;
  logic [23:0] mant_a0, mant_b0;
  logic        is_zero_a0, is_zero_b0, is_inf_a0, is_inf_b0, is_nan_a0, is_nan_b0, is_denorm_a0, is_denorm_b0;
  logic [2:0]  out_tag0;
  logic [15:0] nan_count0;

  always #5 clk = ~clk;

  fpu_operand_unpack #(.FTZ(1), .TAG_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .sub(sub),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .sign_a(sign_a),
    .sign_b_eff(sign_b_eff), .exp_a(exp_a), .exp_b(exp_b), .frac_a(frac_a), .frac_b(frac_b),
    .mant_a(mant_a), .mant_b(mant_b), .is_zero_a(is_zero_a), .is_zero_b(is_zero_b),
    .is_inf_a(is_inf_a), .is_inf_b(is_inf_b), .is_nan_a(is_nan_a), .is_nan_b(is_nan_b),
    .is_denorm_a(is_denorm_a), .is_denorm_b(is_denorm_b), .out_tag(out_tag),
    .clr_stats(clr_stats), .nan_count(nan_count)
  );

  fpu_operand_unpack #(.FTZ(0), .TAG_W(3), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .a(a), .b(b), .sub(sub),
    .in_tag(in_tag), .out_valid(out_valid0), .out_ready(out_ready), .sign_a(sign_a0),
    .sign_b_eff(sign_b_eff0), .exp_a(exp_a0), .exp_b(exp_b0), .frac_a(frac_a0), .frac_b(frac_b0),
    .mant_a(mant_a0), .mant_b(mant_b0), .is_zero_a(is_zero_a0), .is_zero_b(is_zero_b0),
    .is_inf_a(is_inf_a0), .is_inf_b(is_inf_b0), .is_nan_a(is_nan_a0), .is_nan_b(is_nan_b0),
    .is_denorm_a(is_denorm_a0), .is_denorm_b(is_denorm_b0), .out_tag(out_tag0),
    .clr_stats(clr_stats), .nan_count(nan_count0)
  );

  // Observed pair: {A: sign,exp,frac,mant,zero,inf,nan,den ; B: same ; tag}
  logic [127:0] obs1, obs0;
  assign obs1 = {5'b0, sign_a, exp_a, frac_a, mant_a, is_zero_a, is_inf_a, is_nan_a, is_denorm_a,
                 sign_b_eff, exp_b, frac_b, mant_b, is_zero_b, is_inf_b, is_nan_b, is_denorm_b, out_tag};
  assign obs0 = {5'b0, sign_a0, exp_a0, frac_a0, mant_a0, is_zero_a0, is_inf_a0, is_nan_a0, is_denorm_a0,
                 sign_b_eff0, exp_b0, frac_b0, mant_b0, is_zero_b0, is_inf_b0, is_nan_b0, is_denorm_b0, out_tag0};

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [2:0]  tag;
  } entry_t;

  entry_t q[$];
  int     cnt_m;
  int     n_acc;
  int     ntests;
  int     nfail;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    ntests++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int is_nan_val(input logic [31:0] x);
    return ((x[30:23] == 8'hFF) && (x[22:0] != 23'd0)) ? 1 : 0;
  endfunction

  // Reference for one operand from the class rules, with plain integer arithmetic
  function automatic logic [59:0] ref_op(input logic [31:0] x, input logic neg, input int ftz);
    int e, f, fo, m;
    logic zero, inf, nan, den;
    e    = int'(x[30:23]);
    f    = int'(x[22:0]);
    nan  = (e == 255) && (f != 0);
    inf  = (e == 255) && (f == 0);
    den  = (e == 0) && (f != 0);
    zero = (e == 0) && ((f == 0) || (ftz == 1));
    fo   = (den && ftz == 1) ? 0 : f;
    m    = (e != 0) ? (f + 8388608) : fo;
    return {x[31] ^ neg, 8'(e), 23'(fo), 24'(m), zero, inf, nan, den};
  endfunction

  function automatic logic [127:0] exp_pair(input entry_t en, input int ftz);
    return {5'b0, ref_op(en.a, 1'b0, ftz), ref_op(en.b, en.sub, ftz), en.tag};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0:       return {s, 31'd0};
      1:       return {s, 8'h00, 23'($urandom_range(1, 8388607))};
      2:       return {s, 8'hFF, 23'd0};
      3:       return {s, 8'hFF, 23'($urandom_range(1, 8388607))};
      default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  // One clock: check DUT against the model before the edge, then advance the model
  task automatic step();
    logic   acc;
    int     nn;
    entry_t en;
    @(negedge clk);
    chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
    chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
    chk("in_ready_ftz0", 128'(in_ready0), 128'(q.size() < 2));
    chk("out_valid_ftz0", 128'(out_valid0), 128'(q.size() > 0));
    chk("nan_count", 128'(nan_count), 128'(cnt_m));
    chk("nan_count_ftz0", 128'(nan_count0), 128'(cnt_m));
    if (q.size() > 0) begin
      chk("data_ftz1", obs1, exp_pair(q[0], 1));
      chk("data_ftz0", obs0, exp_pair(q[0], 0));
    end
    acc = in_valid && (q.size() < 2);
    if (q.size() > 0 && out_ready) void'(q.pop_front());
    if (acc) begin
      en.a = a; en.b = b; en.sub = sub; en.tag = in_tag;
      q.push_back(en);
      n_acc++;
    end
    if (clr_stats) cnt_m = 0;
    else if (acc) begin
      nn = cnt_m + is_nan_val(a) + is_nan_val(b);
      cnt_m = (nn > 65535) ? 65535 : nn;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    ntests = 0; nfail = 0; cnt_m = 0; n_acc = 0;
    rst = 1'b1; in_valid = 1'b0; sub = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
    a = '0; b = '0; in_tag = '0;
    #2;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_nan_count", 128'(nan_count), 128'(0));
    chk("rst_data", obs1, 128'(0));
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    // Normal operands, subtract
    a = 32'h3F800000; b = 32'h40000000; sub = 1'b1; in_tag = 3'd5; out_ready = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ex1_out_valid", 128'(out_valid), 128'(1));
    chk("ex1_sign_b_eff", 128'(sign_b_eff), 128'(1));
    chk("ex1_exp_a", 128'(exp_a), 128'(8'h7F));
    chk("ex1_exp_b", 128'(exp_b), 128'(8'h80));
    chk("ex1_mant_a", 128'(mant_a), 128'(24'h800000));
    chk("ex1_mant_b", 128'(mant_b), 128'(24'h800000));
    chk("ex1_flags", 128'({is_zero_a, is_inf_a, is_nan_a, is_denorm_a, is_zero_b, is_inf_b, is_nan_b, is_denorm_b}), 128'(0));
    chk("ex1_tag", 128'(out_tag), 128'(5));
    step();

    // NaN / -Inf
    a = 32'h7FC00000; b = 32'hFF800000; sub = 1'b0; in_tag = 3'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ex2_nan_a", 128'(is_nan_a), 128'(1));
    chk("ex2_inf_b", 128'(is_inf_b), 128'(1));
    chk("ex2_sign_b_eff", 128'(sign_b_eff), 128'(1));
    chk("ex2_nan_count", 128'(nan_count), 128'(1));
    step();

    // Denormal and negative zero, both FTZ settings
    a = 32'h00000001; b = 32'h80000000; in_tag = 3'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ex3_zero_a", 128'(is_zero_a), 128'(1));
    chk("ex3_denorm_a", 128'(is_denorm_a), 128'(1));
    chk("ex3_frac_a", 128'(frac_a), 128'(0));
    chk("ex3_mant_a", 128'(mant_a), 128'(0));
    chk("ex3_zero_b", 128'(is_zero_b), 128'(1));
    chk("ex3_frac_a_noftz", 128'(frac_a0), 128'(1));
    chk("ex3_mant_a_noftz", 128'(mant_a0), 128'(24'h000001));
    chk("ex3_zero_a_noftz", 128'(is_zero_a0), 128'(0));
    step();

    // Eight tagged pairs with out_ready toggling 1,0,0,1
    n_acc = 0;
    for (int k = 0; k < 40 && (n_acc < 8 || q.size() > 0); k++) begin
      in_valid  = (n_acc < 8);
      in_tag    = 3'(n_acc);
      a = rnd_op(); b = rnd_op(); sub = 1'($urandom_range(0, 1));
      out_ready = ((k % 4) == 0) || ((k % 4) == 3);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("stream_drained", 128'(out_valid), 128'(0));
    chk("stream_count", 128'(n_acc), 128'(8));

    // Randomized traffic with random backpressure and occasional clears
    for (int k = 0; k < 400; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      clr_stats = ($urandom_range(0, 15) == 0);
      a = rnd_op(); b = rnd_op(); sub = 1'($urandom_range(0, 1)); in_tag = 3'($urandom);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; clr_stats = 1'b0;
    for (int k = 0; k < 5 && q.size() > 0; k++) step();
    chk("random_drained", 128'(out_valid), 128'(0));

    // Saturation of the NaN counter
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0; a = 32'h7FC00001; b = 32'hFFA00000; in_valid = 1'b1; out_ready = 1'b1;
    repeat (32767) step();
    chk("sat_preload", 128'(nan_count), 128'(16'hFFFE));
    step();
    chk("sat_clamp", 128'(nan_count), 128'(16'hFFFF));
    step();
    chk("sat_hold", 128'(nan_count), 128'(16'hFFFF));
    clr_stats = 1'b1;
    step();
    chk("clr_wins", 128'(nan_count), 128'(0));
    clr_stats = 1'b0; in_valid = 1'b0;
    step();
    step();

    // Fill OR and SK, then reset mid-cycle
    out_ready = 1'b0; in_valid = 1'b1; a = 32'h7FC00000; b = rnd_op();
    step();
    step();
    in_valid = 1'b0;
    chk("full_in_ready", 128'(in_ready), 128'(0));
    chk("full_out_valid", 128'(out_valid), 128'(1));
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_nan_count", 128'(nan_count), 128'(0));
    chk("midrst_data", obs1, 128'(0));
    q.delete();
    cnt_m = 0;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
